// File: rtl/fetch_unit_pkg.sv
// Shared processor constants: fetch FSM encodings, word stride, boot address.
package fetch_unit_pkg;

    localparam logic [1:0] ST_BOOT    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;

    localparam logic [31:0] WORD_INC         = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_adder.sv
// Plain W-bit adder shared across the core; carry out is dropped (modulo 2^W).
module fetch_unit_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: boot wait, fixed-latency memory read, then hold the word
// for decode until accepted; redirects restart the fetch at the new target.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          MEM_LATENCY = 2   // 1..15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bios_done,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_data,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [3:0]  r_cnt;
    logic [31:0] r_inst_data;
    logic [31:0] r_inst_pc;

    logic [31:0] w_pc_inc;
    logic [31:0] w_redirect_pc;
    logic        w_last;

    fetch_unit_adder #(.W(32)) u_pc_inc (
        .i_a   (r_pc),
        .i_b   (WORD_INC),
        .o_sum (w_pc_inc)
    );

    assign w_redirect_pc = word_align(redirect_addr);
    assign w_last        = (r_cnt == LAT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_cnt       <= 4'd0;
            r_inst_data <= 32'd0;
            r_inst_pc   <= 32'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (bios_done) begin
                        r_state <= ST_REQ;
                        r_cnt   <= 4'd0;
                    end
                end
                ST_REQ: begin
                    // A redirect abandons the read, including on its final cycle.
                    if (redirect_valid) begin
                        r_pc  <= w_redirect_pc;
                        r_cnt <= 4'd0;
                    end else if (w_last) begin
                        r_inst_data <= mem_data;
                        r_inst_pc   <= r_pc;
                        r_cnt       <= 4'd0;
                        r_state     <= ST_DELIVER;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DELIVER: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redirect_pc;
                        r_cnt   <= 4'd0;
                        r_state <= ST_REQ;
                    end else if (inst_ready) begin
                        r_pc    <= w_pc_inc;
                        r_cnt   <= 4'd0;
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    // Every output is decoded from registered state only; decode never loops back.
    assign inst_valid  = (r_state == ST_DELIVER);
    assign inst_data   = r_inst_data;
    assign inst_pc     = r_inst_pc;
    assign mem_address = r_pc;
    assign mem_cs      = (r_state != ST_REQ);
    assign mem_oe      = (r_state == ST_REQ);
    assign mem_we      = 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-checking memory plus a transaction-level fetch model.
module tb_fetch_unit;
    localparam int          L     = 2;
    localparam logic [31:0] RSTPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset, bios_done, redirect_valid, inst_ready;
    logic [31:0] redirect_addr, mem_data, mem_address, inst_data, inst_pc;
    logic        mem_cs, mem_oe, mem_we, inst_valid;

    fetch_unit #(.RESET_PC(RSTPC), .MEM_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .bios_done(bios_done),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a < 32'd12) return ((a >> 2) + 32'd1) * 32'h11;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory returns real data only in the L-th consecutive cycle on one address.
    int          run_n = 0;
    logic [31:0] run_addr = 32'd0;
    int          eff;
    always @(posedge clock) begin
        if (!mem_cs && mem_oe) begin
            run_n    <= (mem_address == run_addr) ? run_n + 1 : 1;
            run_addr <= mem_address;
        end else begin
            run_n <= 0;
        end
    end
    assign eff      = (run_addr == mem_address) ? run_n : 0;
    assign mem_data = (!mem_cs && mem_oe && eff == L - 1) ? memval(mem_address) : 32'hDEAD_BEEF;

    int n_chk = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: after a fetch starts, the word at m_pc is presented L cycles later
    // and stays until accepted or redirected.
    int          cyc = 0, m_ready = 0;
    logic        m_booted = 1'b0, m_fresh = 1'b0, chk_en = 1'b0, exp_valid;
    logic [31:0] m_pc = RSTPC;

    task automatic step(input logic rst, bios, rdy, rv, input logic [31:0] ra);
        @(negedge clock);
        cyc++;
        exp_valid = m_booted && (cyc >= m_ready);
        if (chk_en) begin
            chk("inst_valid", inst_valid, exp_valid);
            chk("mem_we", mem_we, 1'b0);
            chk("mem_cs", mem_cs, !(m_booted && !exp_valid));
            chk("mem_oe", mem_oe, m_booted && !exp_valid);
            if (!exp_valid) chk("mem_address", mem_address, m_pc);
            if (exp_valid) begin
                chk("inst_pc", inst_pc, m_pc);
                chk("inst_data", inst_data, memval(m_pc));
            end
            if (m_fresh && !exp_valid) begin
                chk("rst_inst_data", inst_data, 32'd0);
                chk("rst_inst_pc", inst_pc, 32'd0);
            end
        end
        if (exp_valid) m_fresh = 1'b0;
        reset = rst; bios_done = bios; inst_ready = rdy;
        redirect_valid = rv; redirect_addr = ra;
        if (rst) begin
            m_booted = 1'b0; m_pc = RSTPC; m_fresh = 1'b1; chk_en = 1'b1;
        end else if (!m_booted) begin
            if (bios) begin m_booted = 1'b1; m_ready = cyc + 1 + L; end
        end else if (rv) begin
            m_pc = ra & ~32'h3; m_ready = cyc + 1 + L;
        end else if (exp_valid && rdy) begin
            m_pc = m_pc + 32'd4; m_ready = cyc + 1 + L;
        end
    endtask

    task automatic run_to_valid(input logic rdy);
        for (int k = 0; k < 40 && !(m_booted && cyc + 1 == m_ready); k++)
            step(1'b0, 1'b1, rdy, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; bios_done = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 32'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        // Boot wait with stray redirects, which must be ignored.
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'($urandom % 2), 1'($urandom % 3 == 0), $urandom);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("boot_addr", mem_address, 32'h0);
        chk("boot_cs", mem_cs, 1'b0);
        // Back-to-back stream 0,4,8 with late bios_done toggles ignored.
        for (int i = 0; i < 8; i++) step(1'b0, 1'($urandom % 2), 1'b1, 1'b0, 32'd0);
        // Stall in DELIVER, then release.
        run_to_valid(1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("stall_next_addr", mem_address, inst_pc + 32'd4);
        // Redirect on the final REQ cycle discards that read.
        for (int k = 0; k < 40 && !(m_booted && cyc + 1 == m_ready - 1); k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("redir_addr", mem_address, 32'h100);
        chk("redir_novalid", inst_valid, 1'b0);
        // Wrap from the top word back to zero.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        run_to_valid(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("wrap_addr", mem_address, 32'h0);
        // Reset while an instruction is being presented.
        run_to_valid(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_addr", mem_address, RSTPC);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        // Random traffic: stalls, redirects (some on handshakes), occasional resets.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom % 400 == 0), 1'($urandom % 6 == 0), 1'($urandom % 4 != 0),
                 1'($urandom % 9 == 0), $urandom);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
